// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants for the register-file write arbiter slice.
//               DATA_W / ADDR_W give default widths, NUM_REGS the register
//               count, REG_ZERO the hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int REG_ZERO = 0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter, purely combinational.
// Ports       : req_i      - request vector (bit 0 = req0, bit 1 = req1)
//               enable_i   - grants are only issued while high
//               ptr_i      - current priority pointer (0 = req0 preferred)
//               grant_o    - one-hot grant (all zero when nothing granted)
//               ptr_next_o - pointer value to register after this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       enable_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o,
  output logic       ptr_next_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      if (req_i == 2'b11) begin
        grant_o = ptr_i ? 2'b10 : 2'b01;
      end else begin
        grant_o = req_i;
      end
    end
  end

  // After a grant, priority moves to the other requester; otherwise it holds.
  always_comb begin
    ptr_next_o = ptr_i;
    if (grant_o[0]) begin
      ptr_next_o = 1'b1;
    end else if (grant_o[1]) begin
      ptr_next_o = 1'b0;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file's single write port between the ALU
//               writeback (req0) and the load writeback (req1) through a
//               one-entry output stage with round-robin arbitration.
// Ports       : clk, rst                 - clock, async active-high reset
//               reqN_valid/addr/data     - requester N write request
//               reqN_ready               - requester N accepted this cycle
//               hold                     - stall, blocks commit and accept
//               writeEn/Addr/Data        - register file write port
//               busy_mask                - one-hot of staged destination
//               pending                  - output stage occupied
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  input  logic                 hold,
  output logic                 writeEn,
  output logic [ADDR_W-1:0]    writeAddr,
  output logic [DATA_W-1:0]    writeData,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic                 pending
);

  localparam int C_NREGS = 2 ** ADDR_W;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              ptr_q,       ptr_d;

  logic              w_commit;
  logic              w_can_accept;
  logic [1:0]        w_grant;
  logic [ADDR_W-1:0] w_gnt_addr;
  logic [DATA_W-1:0] w_gnt_data;
  logic              w_load;

  // A committing stage frees itself on the same edge, so a new grant can
  // land without a bubble.
  assign w_commit     = out_valid_q & ~hold;
  assign w_can_accept = ~out_valid_q | w_commit;

  rr_arb2 u_arb (
    .req_i      ({req1_valid, req0_valid}),
    .enable_i   (w_can_accept),
    .ptr_i      (ptr_q),
    .grant_o    (w_grant),
    .ptr_next_o (ptr_d)
  );

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  assign w_gnt_addr = w_grant[1] ? req1_addr : req0_addr;
  assign w_gnt_data = w_grant[1] ? req1_data : req0_data;

  // Writes to the zero register are acknowledged but never staged.
  assign w_load = (|w_grant) && (w_gnt_addr != ADDR_W'(REG_ZERO));

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (w_load) begin
      out_valid_d = 1'b1;
      out_addr_d  = w_gnt_addr;
      out_data_d  = w_gnt_data;
    end else if (w_commit) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      ptr_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign writeEn   = w_commit;
  assign writeAddr = out_addr_q;
  assign writeData = out_data_q;
  assign pending   = out_valid_q;
  assign busy_mask = out_valid_q ? ({{(C_NREGS-1){1'b0}}, 1'b1} << out_addr_q)
                                 : '0;

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed self-checking bench for regfile_write_arbiter.
//               Inputs change 1 ns after posedge; outputs are checked 1 ns
//               after that, well away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          hold = 1'b0;
  logic          writeEn;
  logic [AW-1:0] writeAddr;
  logic [DW-1:0] writeData;
  logic [NR-1:0] busy_mask;
  logic          pending;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Register-file model: captures whatever the write port presents.
  logic [DW-1:0] rf [NR];
  logic          r7_written = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (writeEn) begin
      rf[writeAddr] <= writeData;
      if (writeAddr == 5'd7) r7_written <= 1'b1;
    end
  end

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .hold       (hold),
    .writeEn    (writeEn),
    .writeAddr  (writeAddr),
    .writeData  (writeData),
    .busy_mask  (busy_mask),
    .pending    (pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    hold       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    total_cnt++;
    if ({writeEn, writeAddr, writeData, busy_mask, pending, req0_ready, req1_ready} !== '0)
      $display("FAIL reset_values: we=%b addr=%0d data=%h mask=%h pend=%b rdy=%b%b want all 0",
               writeEn, writeAddr, writeData, busy_mask, pending, req1_ready, req0_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    // Stage r7, then freeze it with hold and reset mid-cycle.
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_0077;
    tick();
    req0_valid = 1'b0;
    hold = 1'b1;
    #1;
    total_cnt++;
    if (busy_mask !== 32'h0000_0080) $display("FAIL reset_staged_mask: got %h want 00000080", busy_mask);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({writeEn, busy_mask, pending} !== '0)
      $display("FAIL reset_async_clear: we=%b mask=%h pend=%b want 0", writeEn, busy_mask, pending);
    else pass_cnt++;
    tick();
    hold = 1'b0;
    rst  = 1'b0;
    repeat (3) tick();
    total_cnt++;
    if (r7_written !== 1'b0) $display("FAIL reset_no_r7_write: got %b want 0", r7_written);
    else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEAD_BEEF;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready, writeEn} !== 3'b100)
      $display("FAIL single_grant: r0rdy=%b r1rdy=%b we=%b want 1 0 0", req0_ready, req1_ready, writeEn);
    else pass_cnt++;
    tick();
    req0_valid = 1'b0;
    #1;
    total_cnt++;
    if ({writeEn, writeAddr, writeData} !== {1'b1, 5'd3, 32'hDEAD_BEEF})
      $display("FAIL single_commit: we=%b addr=%0d data=%h want 1 3 deadbeef", writeEn, writeAddr, writeData);
    else pass_cnt++;
    total_cnt++;
    if (busy_mask !== 32'h0000_0008) $display("FAIL single_mask_set: got %h want 00000008", busy_mask);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({writeEn, busy_mask, pending} !== '0)
      $display("FAIL single_drain: we=%b mask=%h pend=%b want 0", writeEn, busy_mask, pending);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    logic [4:0] prev_addr;
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1;
    req1_valid = 1'b1; req1_addr = 5'd2;
    prev_addr = 5'd0;
    for (int i = 0; i < 6; i++) begin
      req0_data = 32'h100 + i;
      req1_data = 32'h200 + i;
      #1;
      total_cnt++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL contention_grant_%0d: rdy=%b%b want %b", i, req1_ready, req0_ready,
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if ({writeEn, writeAddr} !== {1'b1, prev_addr})
          $display("FAIL contention_commit_%0d: we=%b addr=%0d want 1 %0d", i, writeEn, writeAddr, prev_addr);
        else pass_cnt++;
      end
      prev_addr = (i % 2 == 0) ? 5'd1 : 5'd2;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h55;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if ({writeEn, req0_ready, req1_ready, busy_mask} !== {3'b000, 32'h0000_0020})
        $display("FAIL hold_cycle_%0d: we=%b rdy=%b%b mask=%h want 0 00 00000020",
                 i, writeEn, req1_ready, req0_ready, busy_mask);
      else pass_cnt++;
      tick();
    end
    hold = 1'b0;
    #1;
    total_cnt++;
    if ({writeEn, writeAddr, writeData, req1_ready} !== {1'b1, 5'd5, 32'h55, 1'b1})
      $display("FAIL hold_release: we=%b addr=%0d data=%h r1rdy=%b want 1 5 55 1",
               writeEn, writeAddr, writeData, req1_ready);
    else pass_cnt++;
    tick();
    req1_valid = 1'b0;
    #1;
    total_cnt++;
    if ({writeEn, writeAddr, writeData} !== {1'b1, 5'd6, 32'h66})
      $display("FAIL hold_next_commit: we=%b addr=%0d data=%h want 1 6 66", writeEn, writeAddr, writeData);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reg_zero();
    do_reset();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    #1;
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b10)
      $display("FAIL zero_accept: rdy=%b%b want 10", req1_ready, req0_ready);
    else pass_cnt++;
    tick();
    // Both valid now: req0 must win because the r0 grant moved the pointer.
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
    req1_addr  = 5'd8; req1_data = 32'h88;
    #1;
    total_cnt++;
    if ({writeEn, busy_mask, pending} !== '0)
      $display("FAIL zero_dropped: we=%b mask=%h pend=%b want 0", writeEn, busy_mask, pending);
    else pass_cnt++;
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL zero_next_grant: rdy=%b%b want 01", req1_ready, req0_ready);
    else pass_cnt++;
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_same_addr();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hB;
    #1;
    total_cnt++;
    if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL same_first_grant: rdy=%b%b want 01", req1_ready, req0_ready);
    else pass_cnt++;
    tick();
    req0_valid = 1'b0;
    #1;
    total_cnt++;
    if ({writeEn, writeAddr, writeData, req1_ready} !== {1'b1, 5'd9, 32'hA, 1'b1})
      $display("FAIL same_first_commit: we=%b addr=%0d data=%h r1rdy=%b want 1 9 a 1",
               writeEn, writeAddr, writeData, req1_ready);
    else pass_cnt++;
    tick();
    req1_valid = 1'b0;
    tick();
    total_cnt++;
    if (rf[9] !== 32'hB) $display("FAIL same_final_value: r9=%h want 0000000b", rf[9]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_reg_zero();
    test_same_addr();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_regfile_write_arbiter
`default_nettype wire
